// File: rtl/matrix_stream_loader_if.sv
// matrix_stream_loader_if
// Valid/ready word stream that feeds matrix_stream_loader. Each word carries
// a 2-bit type tag (element, header, clear, idle) next to its data.
// The master drives the words; the slave (the loader) drives in_ready.

interface matrix_stream_loader_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_ctrl;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_ctrl,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_ctrl,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
// Unpacks a framed byte stream (R1, C1, R2, C2 header, then A row-major,
// then B row-major) into two MAX_DIM x MAX_DIM operand arrays. It then pulses
// start for one cycle and stalls the stream until the multiplier reports
// mult_done.
// Optional build macro LOADER_DIMCHECK_EN: a completed header with C1 != R2
// is rejected. The loader flags err, keeps the old operands and dimensions,
// and returns to header collection.

module matrix_stream_loader #(
    parameter  int DATA_W  = 8,
    parameter  int MAX_DIM = 4,
    parameter  int ELEM_W  = 32,
    localparam int DIM_W   = $clog2(MAX_DIM + 1)
) (
    input  logic                              CLK,
    input  logic                              RST,
    matrix_stream_loader_if.slave             stream,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_a,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_b,
    output logic [DIM_W-1:0]                  r1,
    output logic [DIM_W-1:0]                  c1,
    output logic [DIM_W-1:0]                  r2,
    output logic [DIM_W-1:0]                  c2,
    output logic                              start,
    input  logic                              mult_done,
    output logic                              busy,
    output logic                              err
);

    localparam int N_ELEM = MAX_DIM * MAX_DIM;
    localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    typedef enum logic [2:0] {
        HDR,
        LOAD_A,
        LOAD_B,
        START,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        CTRL_ELEM  = 2'd0,
        CTRL_HDR   = 2'd1,
        CTRL_CLEAR = 2'd2,
        CTRL_IDLE  = 2'd3
    } ctrl_t;

    state_t            state;
    ctrl_t             ctrl;
    logic [1:0]        hdr_cnt;

    // R1, C1 and R2 are staged here. The visible dimensions change only when
    // a complete header has been received.
    logic [DIM_W-1:0]  hdr_r1;
    logic [DIM_W-1:0]  hdr_c1;
    logic [DIM_W-1:0]  hdr_r2;

    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic [ELEM_W-1:0] a_mem [N_ELEM];
    logic [ELEM_W-1:0] b_mem [N_ELEM];

    logic              accept;
    logic              hdr_bad;
    logic              dims_ok;
    logic              row_last;
    logic              col_last;
    logic [DIM_W-1:0]  cur_rows;
    logic [DIM_W-1:0]  cur_cols;
    logic [DIM_W-1:0]  in_dim;
    logic [IDX_W-1:0]  wr_idx;
    logic [ELEM_W-1:0] elem;

    // Stream decode: readiness, acceptance and the per-word derived values.
    assign ctrl            = ctrl_t'(stream.in_ctrl);
    assign stream.in_ready = !RST && (state == HDR || state == LOAD_A || state == LOAD_B);
    assign accept          = stream.in_valid && stream.in_ready;

    // Header values are range-checked on the full word. A wide value must not
    // alias into range after truncation to DIM_W bits.
    assign hdr_bad = (stream.in_data == '0) || (stream.in_data > DATA_W'(MAX_DIM));
    assign in_dim  = DIM_W'(stream.in_data);
    assign elem    = ELEM_W'(stream.in_data);

`ifdef LOADER_DIMCHECK_EN
    assign dims_ok = (hdr_c1 == hdr_r2);
`else
    assign dims_ok = 1'b1;
`endif

    // The element walk uses A's dimensions in LOAD_A and B's in LOAD_B.
    assign cur_rows = (state == LOAD_B) ? r2 : r1;
    assign cur_cols = (state == LOAD_B) ? c2 : c1;
    assign row_last = (row == cur_rows - DIM_W'(1));
    assign col_last = (col == cur_cols - DIM_W'(1));
    assign wr_idx   = IDX_W'(row * MAX_DIM + col);

    // Flatten the operand arrays onto the packed output buses.
    for (genvar i = 0; i < N_ELEM; i++) begin : g_pack
        assign mat_a[i*ELEM_W +: ELEM_W] = a_mem[i];
        assign mat_b[i*ELEM_W +: ELEM_W] = b_mem[i];
    end

    // Loader FSM plus operand storage. At most one stream word is consumed
    // per cycle.
    // NOTE: every register here uses non-blocking assignment, so each branch
    // reads the pre-edge values of state, counters and dimensions.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= HDR;
            hdr_cnt <= '0;
            hdr_r1  <= '0;
            hdr_c1  <= '0;
            hdr_r2  <= '0;
            row     <= '0;
            col     <= '0;
            r1      <= '0;
            c1      <= '0;
            r2      <= '0;
            c2      <= '0;
            start   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            // NOTE: the operand arrays are part of the observable reset state,
            // so they are cleared here and are not left undefined like a RAM.
            for (int i = 0; i < N_ELEM; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else begin
            start <= 1'b0;

            if (accept && ctrl == CTRL_CLEAR) begin
                // A clear abandons the frame but keeps stored operands.
                state   <= HDR;
                hdr_cnt <= '0;
                row     <= '0;
                col     <= '0;
                err     <= 1'b0;
            end else begin
                case (state)
                    HDR: begin
                        if (accept) begin
                            unique case (ctrl)
                                CTRL_HDR: begin
                                    if (hdr_bad) begin
                                        err     <= 1'b1;
                                        hdr_cnt <= '0;
                                    end else begin
                                        // Wraps to 0 after the 4th word in
                                        // both the accept and reject cases.
                                        hdr_cnt <= hdr_cnt + 2'd1;
                                        case (hdr_cnt)
                                            2'd0: hdr_r1 <= in_dim;
                                            2'd1: hdr_c1 <= in_dim;
                                            2'd2: hdr_r2 <= in_dim;
                                            default: begin
                                                if (dims_ok) begin
                                                    r1    <= hdr_r1;
                                                    c1    <= hdr_c1;
                                                    r2    <= hdr_r2;
                                                    c2    <= in_dim;
                                                    row   <= '0;
                                                    col   <= '0;
                                                    state <= LOAD_A;
                                                    for (int i = 0; i < N_ELEM; i++) begin
                                                        a_mem[i] <= '0;
                                                        b_mem[i] <= '0;
                                                    end
                                                end else begin
                                                    err <= 1'b1;
                                                end
                                            end
                                        endcase
                                    end
                                end
                                CTRL_ELEM:  err <= 1'b1;
                                CTRL_CLEAR: ;
                                CTRL_IDLE:  ;
                            endcase
                        end
                    end

                    LOAD_A, LOAD_B: begin
                        if (accept) begin
                            unique case (ctrl)
                                CTRL_ELEM: begin
                                    if (state == LOAD_A) begin
                                        a_mem[wr_idx] <= elem;
                                    end else begin
                                        b_mem[wr_idx] <= elem;
                                    end

                                    // Row-major walk: col wraps at the
                                    // column count and then advances row.
                                    if (col_last) begin
                                        col <= '0;
                                        if (row_last) begin
                                            row <= '0;
                                            if (state == LOAD_A) begin
                                                state <= LOAD_B;
                                            end else begin
                                                state <= START;
                                                start <= 1'b1;
                                                busy  <= 1'b1;
                                            end
                                        end else begin
                                            row <= row + DIM_W'(1);
                                        end
                                    end else begin
                                        col <= col + DIM_W'(1);
                                    end
                                end
                                CTRL_HDR:   err <= 1'b1;
                                CTRL_CLEAR: ;
                                CTRL_IDLE:  ;
                            endcase
                        end
                    end

                    // start was raised on entry; it drops back to 0 by the
                    // default assignment at the top of this branch.
                    START: state <= WAIT;

                    WAIT: begin
                        if (mult_done) begin
                            state   <= HDR;
                            busy    <= 1'b0;
                            hdr_cnt <= '0;
                        end
                    end

                    default: state <= HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader
// Scoreboard bench for matrix_stream_loader. Each frame pushes its expected
// operand images and dimensions into a queue. A monitor pops and compares one
// entry on every start pulse. Directed sections cover reset, handshake stalls,
// the error paths and reset during a load. Randomized frames finish the run.

module tb_matrix_stream_loader;

    localparam int DATA_W  = 8;
    localparam int MAX_DIM = 4;
    localparam int ELEM_W  = 32;
    localparam int DIM_W   = 3;
    localparam int MW      = MAX_DIM * MAX_DIM * ELEM_W;

    localparam logic [1:0] C_ELEM = 2'd0;
    localparam logic [1:0] C_HDR  = 2'd1;
    localparam logic [1:0] C_CLR  = 2'd2;
    localparam logic [1:0] C_IDLE = 2'd3;

    typedef struct {
        logic [MW-1:0]      a;
        logic [MW-1:0]      b;
        logic [4*DIM_W-1:0] dims;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             mult_done;
    logic [MW-1:0]    mat_a;
    logic [MW-1:0]    mat_b;
    logic [DIM_W-1:0] r1;
    logic [DIM_W-1:0] c1;
    logic [DIM_W-1:0] r2;
    logic [DIM_W-1:0] c2;
    logic             start;
    logic             busy;
    logic             err;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    exp_t last_exp;
    int   ea[MAX_DIM][MAX_DIM];
    int   eb[MAX_DIM][MAX_DIM];

    matrix_stream_loader_if #(.DATA_W(DATA_W)) bus ();

    matrix_stream_loader #(
        .DATA_W (DATA_W),
        .MAX_DIM(MAX_DIM),
        .ELEM_W (ELEM_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .stream   (bus),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .r1       (r1),
        .c1       (c1),
        .r2       (r2),
        .c2       (c2),
        .start    (start),
        .mult_done(mult_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference image of a matrix: element (r,c) sits at slot r*MAX_DIM+c.
    // Slots outside the loaded dimensions are zero.
    function automatic logic [MW-1:0] pack(input int m[MAX_DIM][MAX_DIM], input int nr, input int nc);
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                v[(r*MAX_DIM + c)*ELEM_W +: ELEM_W] = m[r][c];
            end
        end
        return v;
    endfunction

    // Present one word and hold it until the loader takes it. The task is
    // entered and left on a negedge.
    task automatic send(input logic [1:0] ctrl, input logic [7:0] data);
        int n;
        n = 0;
        bus.in_ctrl  = ctrl;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", bus.in_ready);
        end
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    // gap 0: back-to-back. gap 1: one empty cycle before every word.
    // gap 2: random empty cycles or idle-typed words.
    task automatic put(input logic [1:0] ctrl, input int data, input int gap);
        if (gap == 1) begin
            @(negedge CLK);
        end else if (gap == 2) begin
            case ($urandom_range(0, 3))
                0:       repeat ($urandom_range(1, 2)) @(negedge CLK);
                1:       send(C_IDLE, 8'($urandom_range(0, 255)));
                default: ;
            endcase
        end
        send(ctrl, data[7:0]);
    endtask

    // Send a full frame from ea/eb and queue its expected result. When held
    // is 1, R1 has already been accepted.
    task automatic load_frame(input int fr1, input int fc1, input int fr2, input int fc2,
                              input int gap, input bit held);
        exp_t e;
        if (!held) put(C_HDR, fr1, gap);
        put(C_HDR, fc1, gap);
        put(C_HDR, fr2, gap);
        put(C_HDR, fc2, gap);
        e.a    = pack(ea, fr1, fc1);
        e.b    = pack(eb, fr2, fc2);
        e.dims = {DIM_W'(fr1), DIM_W'(fc1), DIM_W'(fr2), DIM_W'(fc2)};
        sb.push_back(e);
        last_exp = e;
        for (int r = 0; r < fr1; r++)
            for (int c = 0; c < fc1; c++)
                put(C_ELEM, ea[r][c], gap);
        for (int r = 0; r < fr2; r++)
            for (int c = 0; c < fc2; c++)
                put(C_ELEM, eb[r][c], gap);
        check("start_pulse", start, 1);
        check("busy_rise", busy, 1);
        check("ready_low_start", bus.in_ready, 0);
        @(negedge CLK);
        check("start_one_cycle", start, 0);
        check("busy_wait", busy, 1);
    endtask

    // Optionally stall a header word during WAIT, then pulse mult_done.
    task automatic release_mult(input int delay, input bit hold, input int held);
        repeat (delay) @(negedge CLK);
        if (hold) begin
            bus.in_ctrl  = C_HDR;
            bus.in_data  = held[7:0];
            bus.in_valid = 1'b1;
            repeat (3) @(negedge CLK);
            check("hold_stalled", bus.in_ready, 0);
            check("hold_keep_a", mat_a, last_exp.a);
            check("hold_keep_b", mat_b, last_exp.b);
        end
        mult_done = 1'b1;
        @(negedge CLK);
        mult_done = 1'b0;
        check("ready_after_done", bus.in_ready, 1);
        check("busy_after_done", busy, 0);
        check("retain_a", mat_a, last_exp.a);
        check("retain_dims", {r1, c1, r2, c2}, last_exp.dims);
        if (hold) begin
            @(negedge CLK);
            bus.in_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor: every start pulse consumes one expected frame.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (start === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_unexpected_start: start=1 with no frame queued, expected start=0");
            end else begin
                e = sb.pop_front();
                check("sb_mat_a", mat_a, e.a);
                check("sb_mat_b", mat_b, e.b);
                check("sb_dims", {r1, c1, r2, c2}, e.dims);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [MW-1:0] v;
        int  nr1, nc1, nr2, nc2;
        int  mr1, mc1, mr2, mc2;
        int  k;
        bit  held, hold;

        RST          = 1'b1;
        mult_done    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ctrl  = C_IDLE;
        bus.in_data  = '0;
        repeat (3) @(negedge CLK);
        check("rst_ready_low", bus.in_ready, 0);
        RST = 1'b0;
        #1;
        check("rst_ready_high", bus.in_ready, 1);
        check("rst_mat_a", mat_a, 0);
        check("rst_mat_b", mat_b, 0);
        check("rst_dims", {r1, c1, r2, c2}, 0);
        check("rst_flags", {start, busy, err}, 0);
        @(negedge CLK);

        // Basic 2x2 frame. In WAIT, a held header word (4) is stalled and is
        // then taken after mult_done.
        ea[0][0] = 1; ea[0][1] = 2; ea[1][0] = 3; ea[1][1] = 4;
        eb[0][0] = 5; eb[0][1] = 6; eb[1][0] = 7; eb[1][1] = 8;
        load_frame(2, 2, 2, 2, 0, 1'b0);
        release_mult(2, 1'b1, 4);

        // Max rows, non-square A, and B as a column. Valid toggles.
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++) begin
                ea[r][c] = $urandom_range(1, 255);
                eb[r][c] = $urandom_range(1, 255);
            end
        load_frame(4, 3, 3, 1, 1, 1'b1);
        release_mult(3, 1'b0, 0);

        // A bad header value restarts header collection; err is sticky.
        put(C_HDR, 3, 0);
        put(C_HDR, 2, 0);
        put(C_HDR, 5, 0);
        check("err_bad_hdr", err, 1);
        repeat (4) put(C_HDR, 2, 0);
        check("err_sticky", err, 1);
        check("hdr_restart_dims", {r1, c1, r2, c2}, {4{3'd2}});
        check("hdr_zero_a", mat_a, 0);
        put(C_CLR, 0, 0);
        check("clear_err", err, 0);

        // A header word during LOAD_A is dropped, and the element position
        // does not advance.
        repeat (4) put(C_HDR, 2, 0);
        check("err_clean_load", err, 0);
        put(C_ELEM, 11, 0);
        put(C_ELEM, 12, 0);
        put(C_HDR, 9, 0);
        check("err_hdr_in_load", err, 1);
        put(C_ELEM, 13, 0);
        v = '0;
        v[0*ELEM_W +: ELEM_W] = 11;
        v[1*ELEM_W +: ELEM_W] = 12;
        v[4*ELEM_W +: ELEM_W] = 13;
        check("elem_count_kept", mat_a, v);
        put(C_CLR, 0, 0);
        check("clear_in_load", err, 0);
        put(C_ELEM, 7, 0);
        check("err_elem_in_hdr", err, 1);
        check("hdr_discard_elem", mat_a, v);
        put(C_CLR, 0, 0);
        check("clear_again", err, 0);

        // Header 2,3,2,2 has C1 != R2.
`ifdef LOADER_DIMCHECK_EN
        put(C_HDR, 2, 0);
        put(C_HDR, 3, 0);
        put(C_HDR, 2, 0);
        put(C_HDR, 2, 0);
        check("dimcheck_err", err, 1);
        check("dimcheck_keep_a", mat_a, v);
        put(C_CLR, 0, 0);
`else
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++) begin
                ea[r][c] = $urandom_range(0, 255);
                eb[r][c] = $urandom_range(0, 255);
            end
        load_frame(2, 3, 2, 2, 0, 1'b0);
        release_mult(1, 1'b0, 0);
`endif

        // Reset during a load aborts the load; a later mult_done is ignored.
        repeat (4) put(C_HDR, 3, 0);
        put(C_ELEM, 21, 0);
        put(C_ELEM, 22, 0);
        put(C_ELEM, 23, 0);
        put(C_HDR, 1, 0);
        check("err_before_rst", err, 1);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid_ready_low", bus.in_ready, 0);
        mult_done = 1'b1;
        @(negedge CLK);
        mult_done = 1'b0;
        RST       = 1'b0;
        #1;
        check("rst_mid_mat_a", mat_a, 0);
        check("rst_mid_mat_b", mat_b, 0);
        check("rst_mid_dims", {r1, c1, r2, c2}, 0);
        check("rst_mid_flags", {start, busy, err}, 0);
        check("rst_mid_ready", bus.in_ready, 1);
        @(negedge CLK);
        mult_done = 1'b1;
        @(negedge CLK);
        mult_done = 1'b0;
        check("done_ignored_busy", busy, 0);
        check("done_ignored_ready", bus.in_ready, 1);
        ea[0][0] = 9;
        eb[0][0] = 3;
        load_frame(1, 1, 1, 1, 0, 1'b0);
        release_mult(0, 1'b0, 0);

        // Randomized frames with gaps, idle words, stray bad headers and held
        // headers.
        held = 1'b0;
        nr1  = $urandom_range(1, MAX_DIM);
        nc1  = $urandom_range(1, MAX_DIM);
`ifdef LOADER_DIMCHECK_EN
        nr2  = nc1;
`else
        nr2  = $urandom_range(1, MAX_DIM);
`endif
        nc2  = $urandom_range(1, MAX_DIM);
        for (int it = 0; it < 24; it++) begin
            if (!held && $urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) put(C_HDR, $urandom_range(1, MAX_DIM), 2);
                put(C_HDR, ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_DIM + 1, 255), 2);
                check("rnd_bad_hdr_err", err, 1);
                put(C_CLR, 0, 2);
                check("rnd_clear_err", err, 0);
            end
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++) begin
                    ea[r][c] = $urandom_range(0, 255);
                    eb[r][c] = $urandom_range(0, 255);
                end
            load_frame(nr1, nc1, nr2, nc2, 2, held);
            mr1 = $urandom_range(1, MAX_DIM);
            mc1 = $urandom_range(1, MAX_DIM);
`ifdef LOADER_DIMCHECK_EN
            mr2 = mc1;
`else
            mr2 = $urandom_range(1, MAX_DIM);
`endif
            mc2  = $urandom_range(1, MAX_DIM);
            hold = ($urandom_range(0, 2) == 0);
            release_mult($urandom_range(0, 4), hold, mr1);
            held = hold;
            nr1  = mr1;
            nc1  = mc1;
            nr2  = mr2;
            nc2  = mc2;
        end

        repeat (5) @(negedge CLK);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
